// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clk_div_gen divider channels.
// Covers reset defaults, period clamping and high-phase decode.
package clk_div_pkg;

  localparam int DEF_RST_PERIOD = 5;
  localparam int DEF_RST_HIGH   = 2;

  typedef enum logic [1:0] {
    HI_NORMAL     = 2'd0,
    HI_CONST_LOW  = 2'd1,
    HI_CONST_HIGH = 2'd2
  } high_mode_e;

  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < 32'd2) ? 32'd2 : p;
  endfunction

  // p is expected to be already clamped
  function automatic high_mode_e decode_high(input logic [31:0] p, input logic [31:0] h);
    if (h == 32'd0)
      return HI_CONST_LOW;
    else if (h >= p)
      return HI_CONST_HIGH;
    else
      return HI_NORMAL;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: up-counter over the active period, shadow config that is
// applied only at a period boundary, and registered level plus edge strobes.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CW         = 8,
  parameter int RST_PERIOD = DEF_RST_PERIOD,
  parameter int RST_HIGH   = DEF_RST_HIGH
) (
  input  logic          clk125,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] high,
  input  logic          cfg_load,
  input  logic          sync,
  output logic          div_clk,
  output logic          div_rise,
  output logic          div_fall,
  output logic          cfg_pending
);

  localparam logic [CW-1:0] RST_P    = CW'(clamp_period(32'(RST_PERIOD)));
  localparam logic [CW-1:0] RST_H    = CW'(RST_HIGH);
  localparam high_mode_e    RST_MODE = decode_high(32'(RST_P), 32'(RST_H));

  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] pa, pa_n;
  logic [CW-1:0] ha, ha_n;
  logic [CW-1:0] ps, hs;
  high_mode_e    mode, mode_n;
  logic          pending, pend_n;
  logic          en_q;
  logic          clk_n, rise_n, fall_n;

  logic [CW-1:0] src_p, src_h, new_p;
  high_mode_e    new_mode;
  logic          wrap, apply;

  // A load arriving on the boundary cycle takes effect at that boundary.
  assign src_p    = cfg_load ? period : ps;
  assign src_h    = cfg_load ? high   : hs;
  assign new_p    = CW'(clamp_period(32'(src_p)));
  assign new_mode = decode_high(32'(new_p), 32'(src_h));
  assign wrap     = en_q && (cnt == pa - 1'b1);
  assign apply    = !en || !en_q || sync || wrap;

  always_comb begin
    cnt_n  = cnt + 1'b1;
    pa_n   = pa;
    ha_n   = ha;
    mode_n = mode;
    pend_n = pending | cfg_load;
    clk_n  = 1'b0;
    if (apply) begin
      cnt_n  = '0;
      pa_n   = new_p;
      ha_n   = src_h;
      mode_n = new_mode;
      pend_n = 1'b0;
    end
    if (en) begin
      case (mode_n)
        HI_CONST_HIGH: clk_n = 1'b1;
        HI_CONST_LOW:  clk_n = 1'b0;
        default:       clk_n = (cnt_n < ha_n);
      endcase
    end
    rise_n = clk_n & ~div_clk;
    fall_n = ~clk_n & div_clk;
  end

  always_ff @(posedge clk125) begin
    if (rst) begin
      cnt         <= '0;
      pa          <= RST_P;
      ha          <= RST_H;
      mode        <= RST_MODE;
      ps          <= CW'(RST_PERIOD);
      hs          <= RST_H;
      pending     <= 1'b0;
      en_q        <= 1'b0;
      div_clk     <= 1'b0;
      div_rise    <= 1'b0;
      div_fall    <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      pa       <= pa_n;
      ha       <= ha_n;
      mode     <= mode_n;
      pending  <= pend_n;
      en_q     <= en;
      div_clk  <= clk_n;
      div_rise <= rise_n;
      div_fall <= fall_n;
      if (cfg_load) begin
        ps <= period;
        hs <= high;
      end
    end
  end

  assign cfg_pending = pending;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider on clk125: slices the config buses per channel
// and fans the common sync strobe out to every channel.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int CW         = 8,
  parameter int RST_PERIOD = DEF_RST_PERIOD,
  parameter int RST_HIGH   = DEF_RST_HIGH
) (
  input  logic              clk125,
  input  logic              rst,
  input  logic [NCH-1:0]    div_en,
  input  logic [NCH*CW-1:0] div_period,
  input  logic [NCH*CW-1:0] div_high,
  input  logic [NCH-1:0]    cfg_load,
  input  logic              sync,
  output logic [NCH-1:0]    div_clk,
  output logic [NCH-1:0]    div_rise,
  output logic [NCH-1:0]    div_fall,
  output logic [NCH-1:0]    cfg_pending
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(
      .CW         (CW),
      .RST_PERIOD (RST_PERIOD),
      .RST_HIGH   (RST_HIGH)
    ) u_chan (
      .clk125      (clk125),
      .rst         (rst),
      .en          (div_en[i]),
      .period      (div_period[i*CW +: CW]),
      .high        (div_high[i*CW +: CW]),
      .cfg_load    (cfg_load[i]),
      .sync        (sync),
      .div_clk     (div_clk[i]),
      .div_rise    (div_rise[i]),
      .div_fall    (div_fall[i]),
      .cfg_pending (cfg_pending[i])
    );
  end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised multi-channel clock divider running from the 125 MHz serial clock. Each channel produces a divided clock level plus single-cycle rise and fall strobes, all with a programmable period and high time. New settings take effect glitch-free at a period boundary, and a common sync input phase-aligns all channels. It drives pixel-rate and slower timing in the camera path; any global clock-buffer insertion for the level outputs happens at the top level, not in this block.

## Interface
Parameters:
- NCH, 2: number of independent divider channels.
- CW, 8: counter/config width per channel.
- RST_PERIOD, 5: period (clk125 cycles) loaded into every channel's active config at reset.
- RST_HIGH, 2: high time loaded into every channel's active config at reset.

Ports:
- clk125  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- div_en  in  NCH  per-channel run enable, level.
- div_period  in  NCH*CW  requested period P per channel (channel i at [i*CW +: CW]).
- div_high  in  NCH*CW  requested high time H per channel.
- cfg_load  in  NCH  per-channel 1-cycle strobe: capture div_period/div_high into the shadow config.
- sync  in  1  1-cycle strobe: restart all enabled channels at count 0.
- div_clk  out  NCH  divided clock level, registered.
- div_rise  out  NCH  1-cycle pulse in the first cycle div_clk is high.
- div_fall  out  NCH  1-cycle pulse in the first cycle div_clk is low after being high.
- cfg_pending  out  NCH  shadow config captured, not yet active.

## Operation
- Per channel: active (Pa, Ha), shadow (Ps, Hs), counter cnt[CW-1:0], pending flag.
- Clamping when values become active: P<2 -> P=2; H>=P -> div_clk constant high while enabled; H=0 -> constant low.
- Running: cnt counts 0..Pa-1 and wraps to 0. div_clk=1 exactly in cycles where cnt<Ha.
- cfg_load[i]: Ps/Hs <= inputs, pending <= 1. A second load while pending overwrites the shadow.
- Config apply: at wrap (cnt==Pa-1 -> 0), Pa/Ha <= Ps/Hs and pending <= 0. The next period uses the new values from cnt=0.
- Config apply also happens immediately when the channel is disabled, or when sync is high.
- cfg_load in the same cycle as wrap or sync: the new input values apply at that boundary, and pending stays 0.
- Disabled (div_en=0): cnt held 0, div_clk 0. If div_clk was 1, div_fall pulses once.
- Enable edge (div_en 0->1 sampled at edge k): from k, cnt=0 and div_clk=(0<Ha). div_rise pulses then if Ha>0.
- sync: every enabled channel takes cnt<=0 at the next edge and applies any pending config. div_clk follows the cnt=0 rule, and strobes fire only on actual level changes.
- Strobes: div_rise = div_clk & ~div_clk_prev; div_fall = ~div_clk & div_clk_prev. Both are registered in the same cycle as the div_clk change.
- Reset: cnt=0, Pa=Ps=RST_PERIOD, Ha=Hs=RST_HIGH, pending=0, div_clk=0, div_rise=0, div_fall=0. Reset mid-period discards pending config.

## Timing
- All outputs registered; no combinational input-to-output path.
- Latency from div_en/sync/cfg_load at edge k to div_clk change: visible after edge k (1 cycle).
- Frequency = 125 MHz / Pa, duty = Ha/Pa. Minimum period 2 cycles (62.5 MHz, 50%).
- The config change boundary is glitch-free: no high or low phase shorter than min(old, new) phase length.
- Channels are fully independent except for sync.

## Structure
- Package clk_div_pkg:
  - default constants RST_PERIOD/RST_HIGH;
  - clamp_period function (P<2 -> 2);
  - high-phase decode (constant high/low/normal).
- Sub-module clk_div_chan: one channel, holding counter, shadow/active config, pending flag and strobe logic. It is instantiated NCH times by a generate loop in clk_div_gen. Top level only slices buses and fans out sync.

## Test plan
- Reset, div_en=1 with defaults -> div_clk pattern 1,1,0,0,0 repeating (25 MHz, 40%); div_rise every 5th cycle aligned with the first 1.
- Running P=5,H=2, cfg_load P=8,H=4 mid-period -> cfg_pending=1 until the wrap; the next period is 1,1,1,1,0,0,0,0; no short pulse at the boundary.
- P=1,H=1 loaded -> clamped to P=2: div_clk alternates every cycle. P=4,H=4 -> div_clk constant 1, a single div_rise after enable, no div_fall.
- Two channels running with different phases (P=6,H=3), sync pulse -> both show cnt=0 and div_clk=1 on the next cycle, identical thereafter.
- div_en dropped while div_clk=1 -> div_clk=0 next cycle with one div_fall. Pending config applies immediately, and re-enable starts at cnt=0 with the new settings.
- rst asserted mid-period with a pending load -> all outputs 0 next cycle, cfg_pending=0; after release the channel runs with RST_PERIOD/RST_HIGH.
